risc_v_rf: RTL and testbench

Integer register file for the RV32I core: 32 × 32-bit architectural registers (x0–x31), two read ports and one write port. It sits between decode (operand fetch) and writeback. Reads are registered with one-cycle latency. x0 is hard-wired to zero.

---
 rtl/rf_pkg.sv | 13 +
 rtl/rf_read_port.sv | 46 ++++
 rtl/risc_v_rf.sv | 71 +++++++
 tb/tb_risc_v_rf.sv | 143 ++++++++++++++
 4 files changed

// File: rtl/rf_pkg.sv
// Shared types and constants for the RV32I integer register file.
// The optional RF_BYPASS_EN define is consumed by rf_read_port and risc_v_rf.
package rf_pkg;

    localparam int RF_DATA_W    = 32;
    localparam int RF_ADDR_W    = 5;
    localparam int RF_NUM_REGS  = 32;
    localparam int RF_ZERO_ADDR = 0;

    typedef logic [RF_ADDR_W-1:0] rf_addr_t;
    typedef logic [RF_DATA_W-1:0] rf_data_t;

endpackage

// File: rtl/rf_read_port.sv
// One registered read port: enable-hold output register, x0 forcing and,
// when RF_BYPASS_EN is defined, same-edge write-to-read forwarding.
module rf_read_port
    import rf_pkg::*;
#(
    parameter int DATA_W = RF_DATA_W,
    parameter int ADDR_W = RF_ADDR_W
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              re,
    input  logic [ADDR_W-1:0] raddr,
    input  logic [DATA_W-1:0] rd_val,
`ifdef RF_BYPASS_EN
    input  logic              wr,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [DATA_W-1:0] wdata,
`endif
    output logic [DATA_W-1:0] rdata
);

    logic [DATA_W-1:0] rdata_p1;
    logic              zero_hit;

    assign zero_hit = (raddr == ADDR_W'(RF_ZERO_ADDR));

    // Stage p1: output register, only loaded on an enabled read
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rdata_p1 <= '0;
        end else if (re) begin
            if (zero_hit) begin
                rdata_p1 <= '0;
`ifdef RF_BYPASS_EN
            end else if (wr && (raddr == waddr)) begin
                rdata_p1 <= wdata;
`endif
            end else begin
                rdata_p1 <= rd_val;
            end
        end
    end

    assign rdata = rdata_p1;

endmodule

// File: rtl/risc_v_rf.sv
// RV32I integer register file: 2 registered read ports, 1 write port, x0 = 0.
// Define RF_BYPASS_EN to forward same-edge write data to matching reads.
module risc_v_rf
    import rf_pkg::*;
#(
    parameter int DATA_W = RF_DATA_W,
    parameter int ADDR_W = RF_ADDR_W
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              wr,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic              re1,
    input  logic [ADDR_W-1:0] raddr1,
    output logic [DATA_W-1:0] rdata1,
    input  logic              re2,
    input  logic [ADDR_W-1:0] raddr2,
    output logic [DATA_W-1:0] rdata2
);

    localparam int NUM_REGS = (ADDR_W == RF_ADDR_W) ? RF_NUM_REGS : (1 << ADDR_W);

    logic [DATA_W-1:0] regs [NUM_REGS];

    // Stage p0: architectural state; x0 is never written so it stays zero
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                regs[i] <= '0;
            end
        end else if (wr && (waddr != ADDR_W'(RF_ZERO_ADDR))) begin
            regs[waddr] <= wdata;
        end
    end

    rf_read_port #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W)
    ) u_port1 (
        .clk    (clk),
        .reset  (reset),
        .re     (re1),
        .raddr  (raddr1),
        .rd_val (regs[raddr1]),
`ifdef RF_BYPASS_EN
        .wr     (wr),
        .waddr  (waddr),
        .wdata  (wdata),
`endif
        .rdata  (rdata1)
    );

    rf_read_port #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W)
    ) u_port2 (
        .clk    (clk),
        .reset  (reset),
        .re     (re2),
        .raddr  (raddr2),
        .rd_val (regs[raddr2]),
`ifdef RF_BYPASS_EN
        .wr     (wr),
        .waddr  (waddr),
        .wdata  (wdata),
`endif
        .rdata  (rdata2)
    );

endmodule

// File: tb/tb_risc_v_rf.sv
// Directed bench for risc_v_rf with a reference model and per-port scoreboard
// queues; honours RF_BYPASS_EN for the same-edge read/write expectation.
module tb_risc_v_rf;

    logic        clk = 1'b0;
    logic        reset;
    logic        wr;
    logic [4:0]  waddr;
    logic [31:0] wdata;
    logic        re1;
    logic [4:0]  raddr1;
    logic [31:0] rdata1;
    logic        re2;
    logic [4:0]  raddr2;
    logic [31:0] rdata2;

    int n_checks = 0;
    int n_fail   = 0;

    logic [31:0] mdl [32];
    logic [31:0] last1, last2;
    logic [31:0] q1 [$];
    logic [31:0] q2 [$];

    risc_v_rf dut (
        .clk    (clk),
        .reset  (reset),
        .wr     (wr),
        .waddr  (waddr),
        .wdata  (wdata),
        .re1    (re1),
        .raddr1 (raddr1),
        .rdata1 (rdata1),
        .re2    (re2),
        .raddr2 (raddr2),
        .rdata2 (rdata2)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] model_read(input logic r, input logic [4:0] a,
                                              input logic [31:0] prev, input logic w,
                                              input logic [4:0] wa, input logic [31:0] wd);
        if (!r) return prev;
        if (a == 5'd0) return 32'h0;
`ifdef RF_BYPASS_EN
        if (w && wa == a) return wd;
`endif
        return mdl[a];
    endfunction

    function automatic void model_reset();
        for (int i = 0; i < 32; i++) mdl[i] = 32'h0;
        last1 = 32'h0;
        last2 = 32'h0;
    endfunction

    // One clock of stimulus; expected outputs are queued and then checked #1 after the edge.
    task automatic cyc(input logic w, input logic [4:0] wa, input logic [31:0] wd,
                       input logic r1, input logic [4:0] a1,
                       input logic r2, input logic [4:0] a2, input string tag);
        wr = w; waddr = wa; wdata = wd;
        re1 = r1; raddr1 = a1; re2 = r2; raddr2 = a2;
        last1 = model_read(r1, a1, last1, w, wa, wd);
        last2 = model_read(r2, a2, last2, w, wa, wd);
        q1.push_back(last1);
        q2.push_back(last2);
        if (w && wa != 5'd0) mdl[wa] = wd;
        @(posedge clk);
        #1;
        check({tag, "/p1"}, rdata1, q1.pop_front());
        check({tag, "/p2"}, rdata2, q2.pop_front());
    endtask

    initial begin
        reset = 1'b0;
        wr = 1'b0; waddr = '0; wdata = '0;
        re1 = 1'b0; raddr1 = '0; re2 = 1'b0; raddr2 = '0;
        model_reset();
        #2;
        check("reset_rdata1", rdata1, 32'h0);
        check("reset_rdata2", rdata2, 32'h0);
        @(posedge clk); @(posedge clk); #1;
        reset = 1'b1;

        cyc(1'b0, 5'd0, 32'h0, 1'b1, 5'd2, 1'b1, 5'd3, "rd_after_reset");

        cyc(1'b1, 5'd2, 32'hABCD, 1'b0, 5'd0, 1'b0, 5'd0, "wr_x2");
        cyc(1'b0, 5'd0, 32'h0, 1'b1, 5'd2, 1'b1, 5'd2, "dual_rd_x2");

        cyc(1'b1, 5'd2, 32'h1234, 1'b1, 5'd2, 1'b0, 5'd0, "same_edge_x2");
        cyc(1'b0, 5'd0, 32'h0, 1'b1, 5'd2, 1'b1, 5'd2, "after_same_edge");

        cyc(1'b1, 5'd0, 32'h1234, 1'b1, 5'd0, 1'b1, 5'd0, "same_edge_x0");
        cyc(1'b0, 5'd0, 32'h0, 1'b1, 5'd0, 1'b0, 5'd0, "rd_x0");
        cyc(1'b1, 5'd15, 32'h1234, 1'b0, 5'd0, 1'b0, 5'd0, "wr_x15");
        cyc(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 1'b1, 5'd15, "rd_x15");

        for (int i = 6; i <= 9; i++) begin
            cyc(1'b1, 5'(i), 32'h12340 + 32'(i), 1'b0, 5'd0, 1'b0, 5'd0, "burst_wr");
        end
        cyc(1'b0, 5'd0, 32'h0, 1'b1, 5'd6, 1'b1, 5'd7, "rd_6_7");
        cyc(1'b0, 5'd0, 32'h0, 1'b1, 5'd8, 1'b1, 5'd9, "rd_8_9");
        cyc(1'b0, 5'bx, 32'bx, 1'b0, 5'bx, 1'b0, 5'bx, "hold_x_inputs");
        cyc(1'b0, 5'd6, 32'hDEAD, 1'b0, 5'd6, 1'b0, 5'd7, "hold_again");
        cyc(1'b0, 5'd0, 32'h0, 1'b1, 5'd6, 1'b1, 5'd8, "rd_6_8");

        for (int i = 0; i < 40; i++) begin
            cyc(1'($urandom_range(0, 1)), 5'($urandom_range(0, 31)), $urandom,
                1'($urandom_range(0, 1)), 5'($urandom_range(0, 31)),
                1'($urandom_range(0, 1)), 5'($urandom_range(0, 31)), "random");
        end

        cyc(1'b0, 5'd0, 32'h0, 1'b1, 5'd6, 1'b1, 5'd9, "pre_reset_rd");
        #2;
        wr = 1'b1; waddr = 5'd7; wdata = 32'hFFFF_FFFF;
        reset = 1'b0;
        model_reset();
        #1;
        check("async_clr_rdata1", rdata1, 32'h0);
        check("async_clr_rdata2", rdata2, 32'h0);
        @(posedge clk); #1;
        check("reset_held_rdata1", rdata1, 32'h0);
        reset = 1'b1;

        cyc(1'b0, 5'd0, 32'h0, 1'b1, 5'd6, 1'b1, 5'd7, "post_rst_6_7");
        cyc(1'b0, 5'd0, 32'h0, 1'b1, 5'd2, 1'b1, 5'd9, "post_rst_2_9");
        cyc(1'b1, 5'd9, 32'h5A5A_0009, 1'b0, 5'd0, 1'b0, 5'd0, "post_rst_wr");
        cyc(1'b0, 5'd0, 32'h0, 1'b1, 5'd9, 1'b1, 5'd9, "post_rst_rd9");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
